gmii_rx_fcs_check: RTL and testbench

GMII_RX_FCS_CHECK -- requirements
Module: gmii_rx_fcs_check

---
 rtl/gmii_rx_fcs_check.sv | 160 ++++++++++++++++
 tb/tb_gmii_rx_fcs_check.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_fcs_check.sv
// GMII receive checker: removes preamble/SFD, checks CRC-32 and length, counts good/bad frames.
// Build option GMII_RX_STRIP_FCS_EN: hold the last four bytes back so the FCS is never output.
//
// state    | meaning
// IDLE     | waiting for rx_dv with a 0x55 preamble byte
// PREAMBLE | inside preamble, waiting for the 0xD5 SFD
// DATA     | frame bytes: CRC, length and error tracking, byte output
// DROP     | malformed or partial frame, ignored until rx_dv falls
module gmii_rx_fcs_check #(
    parameter int MINLEN = 64,
    parameter int MAXLEN = 1522
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic [7:0]  dout,
    output logic        dven,
    output logic        sof,
    output logic        done,
    output logic        good,
    output logic        bad_crc,
    output logic        bad_len,
    output logic        bad_er,
    output logic [15:0] cnt_good,
    output logic [15:0] cnt_bad
);

    localparam logic [31:0] RESIDUE = 32'hC704DD7B;
    localparam logic [15:0] MIN_LEN = 16'(MINLEN);
    localparam logic [15:0] MAX_LEN = 16'(MAXLEN);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state;
    logic [31:0] crc;
    logic [15:0] len;
    logic        err;
    logic        was_reset;
    logic        crc_ok;
    logic        len_ok;
    logic        frame_ok;
    logic [15:0] len_next;

`ifdef GMII_RX_STRIP_FCS_EN
    logic [31:0] dly;
`endif

    // Reflected (LSB-first) byte update; the register holds the bit-reversed CRC.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    assign crc_ok   = (bitrev32(crc) == RESIDUE);
    assign len_ok   = (len >= MIN_LEN) && (len <= MAX_LEN);
    assign frame_ok = crc_ok && len_ok && !err;
    assign len_next = (len == 16'hFFFF) ? len : len + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            crc       <= '1;
            len       <= '0;
            err       <= 1'b0;
            was_reset <= 1'b1;
            dout      <= '0;
            dven      <= 1'b0;
            sof       <= 1'b0;
            done      <= 1'b0;
            good      <= 1'b0;
            bad_crc   <= 1'b0;
            bad_len   <= 1'b0;
            bad_er    <= 1'b0;
            cnt_good  <= '0;
            cnt_bad   <= '0;
`ifdef GMII_RX_STRIP_FCS_EN
            dly       <= '0;
`endif
        end else begin
            was_reset <= 1'b0;
            dven      <= 1'b0;
            sof       <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    // A frame already in flight when reset released is never trusted.
                    if (rx_dv) begin
                        state <= (!was_reset && rxd == 8'h55) ? PREAMBLE : DROP;
                    end
                end
                PREAMBLE: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end else if (rxd == 8'hD5) begin
                        state <= DATA;
                        crc   <= '1;
                        len   <= '0;
                        err   <= 1'b0;
                    end else if (rxd != 8'h55) begin
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (rx_dv) begin
                        crc <= crc_byte(crc, rxd);
                        len <= len_next;
                        if (rx_er) begin
                            err <= 1'b1;
                        end
`ifdef GMII_RX_STRIP_FCS_EN
                        dly <= {dly[23:0], rxd};
                        if (len >= 16'd4) begin
                            dout <= dly[31:24];
                            dven <= 1'b1;
                            sof  <= (len == 16'd4);
                        end
`else
                        dout <= rxd;
                        dven <= 1'b1;
                        sof  <= (len == 16'd0);
`endif
                    end else begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        good    <= frame_ok;
                        bad_crc <= !crc_ok;
                        bad_len <= !len_ok;
                        bad_er  <= err;
                        if (frame_ok) begin
                            if (cnt_good != 16'hFFFF) cnt_good <= cnt_good + 16'd1;
                        end else begin
                            if (cnt_bad != 16'hFFFF) cnt_bad <= cnt_bad + 16'd1;
                        end
                    end
                end
                DROP: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_fcs_check.sv
// Directed bench for gmii_rx_fcs_check; follows GMII_RX_STRIP_FCS_EN to pick the expected byte stream.
module tb_gmii_rx_fcs_check;

`ifdef GMII_RX_STRIP_FCS_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [7:0]  dout;
    logic        dven, sof, done, good, bad_crc, bad_len, bad_er;
    logic [15:0] cnt_good, cnt_bad;

    gmii_rx_fcs_check #(.MINLEN(64), .MAXLEN(1522)) dut (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .dout(dout), .dven(dven), .sof(sof), .done(done), .good(good),
        .bad_crc(bad_crc), .bad_len(bad_len), .bad_er(bad_er),
        .cnt_good(cnt_good), .cnt_bad(cnt_bad)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int exp_good = 0;
    int exp_bad = 0;

    logic [7:0] frm [0:1599];
    int         frm_len;
    logic [7:0] arp_hdr [0:41] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03,
        8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
        8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03, 8'hC0, 8'hA8, 8'h01, 8'h0A,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01};

    // Output monitor: records what the DUT emits, judged later by the test tasks.
    int         cyc = 0;
    logic [7:0] got [$];
    int         first_dven_cyc, sof_cnt, done_cnt, done_cyc;
    logic       sof_first, d_good, d_bad_crc, d_bad_len, d_bad_er;
    int         b0_cyc, end_cyc;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (dven) begin
            if (got.size() == 0) begin
                first_dven_cyc = cyc;
                sof_first = sof;
            end
            got.push_back(dout);
        end
        if (sof) sof_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            d_good    = good;
            d_bad_crc = bad_crc;
            d_bad_len = bad_len;
            d_bad_er  = bad_er;
        end
    end

    task automatic clear_mon();
        got.delete();
        sof_cnt = 0; done_cnt = 0; first_dven_cyc = -1; done_cyc = -1;
        sof_first = 1'b0; d_good = 1'b0; d_bad_crc = 1'b0; d_bad_len = 1'b0; d_bad_er = 1'b0;
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk);
        rx_dv = dv; rx_er = er; rxd = d;
    endtask

    // Non-reflected MSB-first CRC with each byte fed LSB first, as bits go on the wire.
    task automatic build_fcs(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[31] ^ frm[k][j];
                c = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                frm[n+k][j] = ~c[31-8*k-j];
            end
        end
        frm_len = n + 4;
    endtask

    task automatic load_arp();
        for (int i = 0; i < 60; i++) frm[i] = (i < 42) ? arp_hdr[i] : 8'h00;
        build_fcs(60);
    endtask

    task automatic load_pattern(input int n, input int seed);
        for (int i = 0; i < n; i++) frm[i] = 8'((i * 13 + seed) & 255);
        build_fcs(n);
    endtask

    task automatic send_frame(input int err_idx);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frm_len; i++) begin
            drive(1'b1, (i == err_idx), frm[i]);
            if (i == 0) b0_cyc = cyc + 1;
        end
    endtask

    task automatic end_frame();
        drive(1'b0, 1'b0, 8'h00);
        end_cyc = cyc + 1;
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({dout, dven, sof, done, good, bad_crc, bad_len, bad_er, cnt_good, cnt_bad} !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h req=0", {dout, dven, sof, done, good, bad_crc, bad_len, bad_er, cnt_good, cnt_bad});
        end
        reset = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_arp_good();
        int nexp, errs;
        nexp = STRIP ? 60 : 64;
        load_arp();
        clear_mon();
        send_frame(-1);
        end_frame();
        exp_good++;
        errs = 0;
        for (int i = 0; i < nexp; i++) if (i >= got.size() || got[i] !== frm[i]) errs++;
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL arp_done_count got=%0d req=1", done_cnt); end
        vectors++; if (d_good !== 1'b1 || d_bad_crc !== 1'b0 || d_bad_len !== 1'b0 || d_bad_er !== 1'b0) begin miscompares++; $display("FAIL arp_status got=%b%b%b%b req=1000", d_good, d_bad_crc, d_bad_len, d_bad_er); end
        vectors++; if (got.size() !== nexp) begin miscompares++; $display("FAIL arp_byte_count got=%0d req=%0d", got.size(), nexp); end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL arp_data got=%0d wrong bytes req=0", errs); end
        vectors++; if (sof_first !== 1'b1 || sof_cnt !== 1) begin miscompares++; $display("FAIL arp_sof got=%b/%0d req=1/1", sof_first, sof_cnt); end
        vectors++; if (got.size() == 0 || got[0] !== 8'hFF) begin miscompares++; $display("FAIL arp_first_byte got=%h req=ff", (got.size() == 0) ? 8'hxx : got[0]); end
        vectors++; if (first_dven_cyc - b0_cyc !== (STRIP ? 4 : 0)) begin miscompares++; $display("FAIL arp_latency got=%0d req=%0d", first_dven_cyc - b0_cyc, STRIP ? 4 : 0); end
        vectors++; if (done_cyc !== end_cyc) begin miscompares++; $display("FAIL arp_done_timing got=%0d req=%0d", done_cyc, end_cyc); end
        vectors++; if (cnt_good !== 16'(exp_good) || cnt_bad !== 16'(exp_bad)) begin miscompares++; $display("FAIL arp_counters got=%0d/%0d req=%0d/%0d", cnt_good, cnt_bad, exp_good, exp_bad); end
    endtask

    task automatic test_bad_crc();
        load_arp();
        frm[30] = frm[30] ^ 8'h01;
        clear_mon();
        send_frame(-1);
        end_frame();
        exp_bad++;
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL crc_done_count got=%0d req=1", done_cnt); end
        vectors++; if (d_good !== 1'b0 || d_bad_crc !== 1'b1 || d_bad_len !== 1'b0 || d_bad_er !== 1'b0) begin miscompares++; $display("FAIL crc_status got=%b%b%b%b req=0100", d_good, d_bad_crc, d_bad_len, d_bad_er); end
        vectors++; if (cnt_good !== 16'(exp_good) || cnt_bad !== 16'(exp_bad)) begin miscompares++; $display("FAIL crc_counters got=%0d/%0d req=%0d/%0d", cnt_good, cnt_bad, exp_good, exp_bad); end
    endtask

    task automatic test_rx_er();
        load_pattern(94, 3);
        clear_mon();
        send_frame(50);
        end_frame();
        exp_bad++;
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL er_done_count got=%0d req=1", done_cnt); end
        vectors++; if (d_good !== 1'b0 || d_bad_crc !== 1'b0 || d_bad_len !== 1'b0 || d_bad_er !== 1'b1) begin miscompares++; $display("FAIL er_status got=%b%b%b%b req=0001", d_good, d_bad_crc, d_bad_len, d_bad_er); end
        vectors++; if (cnt_good !== 16'(exp_good) || cnt_bad !== 16'(exp_bad)) begin miscompares++; $display("FAIL er_counters got=%0d/%0d req=%0d/%0d", cnt_good, cnt_bad, exp_good, exp_bad); end
    endtask

    task automatic test_bad_preamble();
        clear_mon();
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h5D);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 8'(i));
        end_frame();
        vectors++; if (done_cnt !== 0 || got.size() !== 0) begin miscompares++; $display("FAIL preamble_dropped got=%0d done %0d bytes req=0 0", done_cnt, got.size()); end
        vectors++; if (cnt_good !== 16'(exp_good) || cnt_bad !== 16'(exp_bad)) begin miscompares++; $display("FAIL preamble_counters got=%0d/%0d req=%0d/%0d", cnt_good, cnt_bad, exp_good, exp_bad); end
        load_arp();
        clear_mon();
        send_frame(-1);
        end_frame();
        exp_good++;
        vectors++; if (done_cnt !== 1 || d_good !== 1'b1) begin miscompares++; $display("FAIL preamble_next_frame got=%0d/%b req=1/1", done_cnt, d_good); end
        vectors++; if (cnt_good !== 16'(exp_good)) begin miscompares++; $display("FAIL preamble_next_count got=%0d req=%0d", cnt_good, exp_good); end
    endtask

    task automatic test_reset_midframe();
        load_arp();
        clear_mon();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, frm[i]);
        reset = 1'b1;
        drive(1'b1, 1'b0, frm[30]);
        drive(1'b1, 1'b0, 8'h55);
        exp_good = 0;
        exp_bad = 0;
        vectors++;
        if ({dout, dven, sof, done, good, bad_crc, bad_len, bad_er, cnt_good, cnt_bad} !== 48'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs got=%h req=0", {dout, dven, sof, done, good, bad_crc, bad_len, bad_er, cnt_good, cnt_bad});
        end
        // Release on a preamble byte followed by a complete valid frame: it must still be dropped.
        clear_mon();
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frm_len; i++) drive(1'b1, 1'b0, frm[i]);
        end_frame();
        vectors++; if (done_cnt !== 0 || got.size() !== 0) begin miscompares++; $display("FAIL midreset_dropped got=%0d done %0d bytes req=0 0", done_cnt, got.size()); end
        vectors++; if (cnt_good !== 16'd0 || cnt_bad !== 16'd0) begin miscompares++; $display("FAIL midreset_counters got=%0d/%0d req=0/0", cnt_good, cnt_bad); end
        clear_mon();
        send_frame(-1);
        end_frame();
        exp_good++;
        vectors++; if (done_cnt !== 1 || d_good !== 1'b1) begin miscompares++; $display("FAIL midreset_next_frame got=%0d/%b req=1/1", done_cnt, d_good); end
        vectors++; if (cnt_good !== 16'(exp_good)) begin miscompares++; $display("FAIL midreset_next_count got=%0d req=%0d", cnt_good, exp_good); end
    endtask

    task automatic test_length();
        int lens [5] = '{40, 63, 64, 1522, 1523};
        bit bl   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 5; t++) begin
            load_pattern(lens[t] - 4, t + 1);
            clear_mon();
            send_frame(-1);
            end_frame();
            if (bl[t]) exp_bad++; else exp_good++;
            vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL len%0d_done_count got=%0d req=1", lens[t], done_cnt); end
            vectors++; if (d_bad_len !== bl[t] || d_bad_crc !== 1'b0 || d_good !== !bl[t]) begin miscompares++; $display("FAIL len%0d_status got=bad_len %b bad_crc %b good %b req=%b 0 %b", lens[t], d_bad_len, d_bad_crc, d_good, bl[t], !bl[t]); end
            vectors++; if (got.size() !== (STRIP ? lens[t] - 4 : lens[t])) begin miscompares++; $display("FAIL len%0d_byte_count got=%0d req=%0d", lens[t], got.size(), STRIP ? lens[t] - 4 : lens[t]); end
            vectors++; if (cnt_good !== 16'(exp_good) || cnt_bad !== 16'(exp_bad)) begin miscompares++; $display("FAIL len%0d_counters got=%0d/%0d req=%0d/%0d", lens[t], cnt_good, cnt_bad, exp_good, exp_bad); end
        end
    endtask

    task automatic test_back_to_back();
        load_arp();
        clear_mon();
        send_frame(-1);
        drive(1'b0, 1'b0, 8'h00);
        send_frame(-1);
        end_frame();
        exp_good += 2;
        vectors++; if (done_cnt !== 2) begin miscompares++; $display("FAIL b2b_done_count got=%0d req=2", done_cnt); end
        vectors++; if (d_good !== 1'b1) begin miscompares++; $display("FAIL b2b_status got=%b req=1", d_good); end
        vectors++; if (got.size() !== (STRIP ? 120 : 128)) begin miscompares++; $display("FAIL b2b_byte_count got=%0d req=%0d", got.size(), STRIP ? 120 : 128); end
        vectors++; if (sof_cnt !== 2) begin miscompares++; $display("FAIL b2b_sof_count got=%0d req=2", sof_cnt); end
        vectors++; if (cnt_good !== 16'(exp_good) || cnt_bad !== 16'(exp_bad)) begin miscompares++; $display("FAIL b2b_counters got=%0d/%0d req=%0d/%0d", cnt_good, cnt_bad, exp_good, exp_bad); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_arp_good();
        test_bad_crc();
        test_rx_er();
        test_bad_preamble();
        test_reset_midframe();
        test_length();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
